// File: rtl/shift_cmd_seq_if.sv
// Bundle between the command sequencer and its two neighbours: the CPU-side
// request/result channels and the 8-bit shifter register it drives.
interface shift_cmd_seq_if #(
  parameter int AMT_W = 4
);
  // Request side
  logic             req_valid;
  logic             req_ready;
  logic [7:0]       req_data;
  logic [1:0]       req_kind;
  logic [AMT_W-1:0] req_amount;

  // Shifter side
  logic [2:0]       op;
  logic [1:0]       shamt;
  logic [7:0]       d_in;
  logic [7:0]       sh_q;

  // Result side
  logic             res_valid;
  logic             res_ready;
  logic [7:0]       res_data;
  logic             res_err;
  logic             busy;

  // Sequencer view: it owns op/shamt/d_in and both ready/valid outputs.
  modport slave (
    input  req_valid, req_data, req_kind, req_amount, sh_q, res_ready,
    output req_ready, op, shamt, d_in, res_valid, res_data, res_err, busy
  );

  // Environment view: CPU command bus plus the shifter register.
  modport master (
    output req_valid, req_data, req_kind, req_amount, sh_q, res_ready,
    input  req_ready, op, shamt, d_in, res_valid, res_data, res_err, busy
  );
endinterface

// File: rtl/shift_cmd_seq.sv
// Command sequencer for the 8-bit shifter: loads a value, then issues shift
// steps of at most MAX_STEP bits until the requested distance is covered.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high. The source holds valid and its payload stable until that edge;
// req_ready and res_valid never depend combinationally on the partner's signal.
module shift_cmd_seq #(
  parameter int MAX_STEP = 3,
  parameter int AMT_W    = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  shift_cmd_seq_if.slave        bus,
  output logic [1:0]            o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_SHIFT  = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_LSL  = 3'b010;
  localparam logic [2:0] OP_LSR  = 3'b011;
  localparam logic [2:0] OP_ASR  = 3'b100;

  state_t           r_state;
  logic [1:0]       r_kind;
  logic [AMT_W-1:0] r_rem;
  logic             r_err;
  logic [2:0]       r_op;
  logic [1:0]       r_shamt;
  logic [7:0]       r_d_in;
  logic             r_req_ready;
  logic             r_res_valid;
  logic             r_res_err;
  logic             r_busy;

  logic [1:0]       w_step;
  logic [2:0]       w_kind_op;

  // Size of the next step: the remaining distance, capped at MAX_STEP.
  assign w_step = (r_rem > AMT_W'(MAX_STEP)) ? 2'(MAX_STEP) : r_rem[1:0];

  always_comb begin
    w_kind_op = OP_NOP;
    case (r_kind)
      2'b00:   w_kind_op = OP_LSL;
      2'b01:   w_kind_op = OP_LSR;
      2'b10:   w_kind_op = OP_ASR;
      default: w_kind_op = OP_NOP;
    endcase
  end

  // r_rem holds the distance not yet issued to the shifter; the step shown on
  // op/shamt has already been subtracted from it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_kind      <= 2'b00;
      r_rem       <= '0;
      r_err       <= 1'b0;
      r_op        <= OP_NOP;
      r_shamt     <= 2'd0;
      r_d_in      <= 8'h00;
      r_req_ready <= 1'b1;
      r_res_valid <= 1'b0;
      r_res_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_kind      <= bus.req_kind;
            r_rem       <= (bus.req_kind == 2'b11) ? '0 : bus.req_amount;
            r_err       <= (bus.req_kind == 2'b11);
            r_op        <= OP_LOAD;
            r_shamt     <= 2'd0;
            r_d_in      <= bus.req_data;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_LOAD;
          end
        end

        S_LOAD, S_SHIFT: begin
          r_d_in <= 8'h00;
          if (r_rem != '0) begin
            r_op    <= w_kind_op;
            r_shamt <= w_step;
            r_rem   <= r_rem - AMT_W'(w_step);
            r_state <= S_SHIFT;
          end else begin
            r_op        <= OP_NOP;
            r_shamt     <= 2'd0;
            r_res_valid <= 1'b1;
            r_res_err   <= r_err;
            r_state     <= S_RESULT;
          end
        end

        S_RESULT: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_res_err   <= 1'b0;
            r_err       <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.op        = r_op;
  assign bus.shamt     = r_shamt;
  assign bus.d_in      = r_d_in;
  assign bus.req_ready = r_req_ready;
  assign bus.res_valid = r_res_valid;
  assign bus.res_err   = r_res_err;
  assign bus.busy      = r_busy;
  // sh_q is the shifter's register output and is held by NOP during RESULT.
  assign bus.res_data  = r_res_valid ? bus.sh_q : 8'h00;
  assign o_dbg_state   = r_state;

endmodule
